// File: rtl/word_ser_pkg.sv
// Shared definitions for the word-to-byte serializer.
//   state_t  : serializer FSM states
//   BYTE_W   : width of one emitted byte
//   next_set : index of the next set mask bit from a start point in a given direction
package word_ser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    // Searches a mask of up to 8 bits. With inclusive set, the start position itself
    // is a candidate; otherwise the search begins one step past it. Returns -1 when
    // no set bit remains inside [0, nbytes).
    function automatic int next_set(input logic [7:0] mask, input int nbytes,
                                    input int start, input logic msb_first,
                                    input logic inclusive);
        int res;
        int p;
        int step;
        res = -1;
        // Walk from the farthest candidate inward so the nearest hit wins.
        for (int k = 7; k >= 0; k--) begin
            step = inclusive ? k : k + 1;
            p = msb_first ? start - step : start + step;
            if (p >= 0 && p < nbytes && mask[p[2:0]]) begin
                res = p;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/word_byte_serializer_pick.sv
// byte_pick: priority encoder over a byte-keep mask.
//   mask       : byte-keep bits of a word
//   cur_idx    : current byte index (ignored when from_start is set)
//   msb_first  : emission direction, 1 = high byte first
//   from_start : 1 = find the first kept byte of the word (inclusive of the start byte)
//                0 = find the next kept byte strictly after cur_idx
//   next_idx   : index found (0 when none)
//   none_left  : no kept byte found
module byte_pick
    import word_ser_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int IDX_W      = $clog2(WORD_BYTES)
) (
    input  logic [WORD_BYTES-1:0] mask,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic                  msb_first,
    input  logic                  from_start,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  none_left
);

    logic [7:0] m8;
    int         start;
    int         found;

    always_comb begin
        m8 = '0;
        m8[WORD_BYTES-1:0] = mask;
        if (from_start) begin
            start = msb_first ? WORD_BYTES - 1 : 0;
        end else begin
            start = int'(cur_idx);
        end
        found     = next_set(m8, WORD_BYTES, start, msb_first, from_start);
        none_left = (found < 0);
        next_idx  = none_left ? '0 : IDX_W'(found);
    end

endmodule

// File: rtl/word_byte_serializer.sv
// word_byte_serializer: splits words of WORD_BYTES bytes into a byte stream,
// emitting only bytes whose keep bit is set, in LSB-first or MSB-first order.
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready              : word handshake
//   in_data, in_keep               : word and per-byte keep mask
//   out_valid/out_ready            : byte handshake
//   out_data, out_idx, out_last    : byte, its index in the word, last kept byte flag
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SEND  | word held, out_data shows the byte at cur_idx
module word_byte_serializer
    import word_ser_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*WORD_BYTES-1:0]       in_data,
    input  logic [WORD_BYTES-1:0]         in_keep,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic [$clog2(WORD_BYTES)-1:0] out_idx,
    output logic                          out_last
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    state_t                         state;
    logic [BYTE_W*WORD_BYTES-1:0]   word_q;
    logic [WORD_BYTES-1:0]          mask_q;
    logic [IDX_W-1:0]               cur_idx;

    logic [IDX_W-1:0]               cur_next;
    logic                           cur_none;
    logic [IDX_W-1:0]               in_first;
    logic                           in_none;
    logic                           out_fire;
    logic                           in_fire;
    int unsigned                    bit_base;

    byte_pick #(.WORD_BYTES(WORD_BYTES), .IDX_W(IDX_W)) u_pick_cur (
        .mask       (mask_q),
        .cur_idx    (cur_idx),
        .msb_first  (MSB_FIRST),
        .from_start (1'b0),
        .next_idx   (cur_next),
        .none_left  (cur_none)
    );

    byte_pick #(.WORD_BYTES(WORD_BYTES), .IDX_W(IDX_W)) u_pick_in (
        .mask       (in_keep),
        .cur_idx    ({IDX_W{1'b0}}),
        .msb_first  (MSB_FIRST),
        .from_start (1'b1),
        .next_idx   (in_first),
        .none_left  (in_none)
    );

    // All outputs except in_ready come straight from flops through the byte mux,
    // so they stay stable while the consumer stalls.
    assign bit_base  = BYTE_W * int'(cur_idx);
    assign out_valid = (state == SEND);
    assign out_last  = out_valid && cur_none;
    assign out_idx   = cur_idx;
    assign out_data  = word_q[bit_base +: BYTE_W];

    assign out_fire  = out_valid && out_ready;
    // Accepting on the last-byte handshake keeps back-to-back words gapless.
    assign in_ready  = !rst && ((state == IDLE) || (out_fire && out_last));
    assign in_fire   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            word_q  <= '0;
            mask_q  <= '0;
            cur_idx <= '0;
        end else if (in_fire) begin
            word_q  <= in_data;
            mask_q  <= in_keep;
            cur_idx <= in_first;
            // An all-zero keep consumes the word without producing bytes.
            state   <= in_none ? IDLE : SEND;
        end else if (out_fire) begin
            mask_q[cur_idx] <= 1'b0;
            if (out_last) begin
                state <= IDLE;
            end else begin
                cur_idx <= cur_next;
            end
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
module tb_word_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_keep;
    logic        out_ready;

    logic        in_ready0, out_valid0, out_last0;
    logic [7:0]  out_data0;
    logic [1:0]  out_idx0;
    logic        in_ready1, out_valid1, out_last1;
    logic [7:0]  out_data1;
    logic [1:0]  out_idx1;

    always #5 clk = ~clk;

    word_byte_serializer #(.WORD_BYTES(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_idx(out_idx0), .out_last(out_last0)
    );

    word_byte_serializer #(.WORD_BYTES(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_keep(in_keep),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] i;
        logic       l;
    } ent_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    ent_t       mq0[$];
    ent_t       mq1[$];
    bit         rz0 = 1'b1;
    bit         rz1 = 1'b1;
    logic [7:0] st0[$];
    logic [7:0] st1[$];
    bit         run = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pending bytes of the held word as a queue in emission order.
    task automatic model_cycle(input string tag, input bit msb, inout ent_t q[$],
                               inout bit rz, inout logic [7:0] st[$],
                               input logic a_rdy, input logic a_vld, input logic a_last,
                               input logic [7:0] a_data, input logic [1:0] a_idx);
        bit exp_rdy;
        int nk;
        int pushed;
        int bi;
        ent_t e;
        exp_rdy = !rst && (q.size() == 0 || (out_ready && q.size() == 1));
        chk({tag, ".in_ready"},  32'(a_rdy),  32'(exp_rdy));
        chk({tag, ".out_valid"}, 32'(a_vld),  32'(q.size() > 0));
        chk({tag, ".out_last"},  32'(a_last), 32'(q.size() > 0 ? q[0].l : 1'b0));
        if (q.size() > 0) begin
            chk({tag, ".out_data"}, 32'(a_data), 32'(q[0].d));
            chk({tag, ".out_idx"},  32'(a_idx),  32'(q[0].i));
        end else if (rz) begin
            chk({tag, ".rst_data"}, 32'(a_data), 32'h0);
            chk({tag, ".rst_idx"},  32'(a_idx),  32'h0);
        end
        if (!rst && a_vld && out_ready) st.push_back(a_data);
        if (rst) begin
            q.delete();
            rz = 1'b1;
        end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) begin
                rz = 1'b0;
                nk = $countones(in_keep);
                pushed = 0;
                for (int k = 0; k < 4; k++) begin
                    bi = msb ? 3 - k : k;
                    if (in_keep[bi]) begin
                        e.d = 8'((in_data >> (8 * bi)) & 32'hff);
                        e.i = 2'(bi);
                        e.l = (pushed == nk - 1);
                        q.push_back(e);
                        pushed++;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                model_cycle("lsb", 1'b0, mq0, rz0, st0, in_ready0, out_valid0, out_last0, out_data0, out_idx0);
                model_cycle("msb", 1'b1, mq1, rz1, st1, in_ready1, out_valid1, out_last1, out_data1, out_idx1);
            end
        end
    end

    // Expected stream packed with the first byte in the least significant position.
    task automatic check_stream(input string nm, inout logic [7:0] st[$],
                                input logic [63:0] exp, input int n);
        chk({nm, ".count"}, 32'(st.size()), 32'(n));
        for (int i = 0; i < n && i < st.size(); i++) begin
            chk($sformatf("%s.byte%0d", nm, i), 32'(st[i]), 32'((exp >> (8 * i)) & 64'hff));
        end
        st.delete();
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = k;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: word %0h not accepted within 50 cycles", d);
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        in_keep  = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_keep   = '0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        push(32'hdeadbeaf, 4'hf);
        idle(6);
        check_stream("t1_lsb", st0, 64'hdeadbeaf, 4);
        check_stream("t1_msb", st1, 64'hafbeadde, 4);

        push(32'hdeadbeaf, 4'b1010);
        idle(4);
        check_stream("t2_lsb", st0, 64'hdebe, 2);
        check_stream("t2_msb", st1, 64'hbede, 2);

        push(32'h11223344, 4'hf);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(1);
        out_ready = 1'b0;
        idle(1);
        out_ready = 1'b1;
        idle(6);
        check_stream("t4_lsb", st0, 64'h11223344, 4);
        check_stream("t4_msb", st1, 64'h44332211, 4);

        push(32'hdeadbeaf, 4'hf);
        push(32'h00000000, 4'h0);
        push(32'h11223344, 4'b0001);
        idle(8);
        check_stream("t5_lsb", st0, 64'h44deadbeaf, 5);
        check_stream("t5_msb", st1, 64'h44afbeadde, 5);

        push(32'hdeadbeaf, 4'hf);
        idle(2);
        rst       = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_ready", 32'(in_ready0), 32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_post_out_valid", 32'(out_valid0), 32'h0);
        chk("t6_post_in_ready",  32'(in_ready0),  32'h1);
        chk("t6_post_out_data",  32'(out_data0),  32'h0);
        idle(5);
        check_stream("t6_lsb", st0, 64'hbeaf, 2);
        check_stream("t6_msb", st1, 64'hadde, 2);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/word_byte_serializer.md
# word_byte_serializer

Converts a stream of 32-bit words into a stream of bytes, one byte per accepted output handshake. Each byte is taken from the word's bit slice starting at byte index × 8, 8 bits wide. A per-word byte-keep mask selects which bytes are emitted. The block sits between a word-wide producer and a byte-wide consumer, such as a UART or byte FIFO, and owns the sequencing of the byte-extraction datapath.

## Interface
- WORD_BYTES, default 4: bytes per input word; legal values 2..8.
- MSB_FIRST, default 0: 0 emits byte 0 (bits [7:0]) first; 1 emits the highest byte first.
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  input word is available.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  8*WORD_BYTES  word to serialize.
- in_keep  input  WORD_BYTES  bit i set means byte i is emitted.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes the byte this cycle.
- out_data  output  8  current byte.
- out_idx  output  $clog2(WORD_BYTES)  byte index of out_data within its word.
- out_last  output  1  out_data is the final kept byte of its word.

## Operation
- States:
  - IDLE: no word held.
  - SEND: a word is held and bytes are pending.
- Input accept happens when in_valid and in_ready are both high:
  - Latch in_data into word_q and in_keep into mask_q.
  - Set cur_idx to the first set bit of in_keep in emission order.
  - If in_keep is 0, the word is consumed and dropped: no output, and the state stays or returns to IDLE.
- SEND behaviour:
  - out_data = word_q[cur_idx*8 +: 8].
  - out_valid = 1.
  - out_last = 1 when no further set bit of mask_q remains after cur_idx in emission order.
- Output handshake, when out_valid and out_ready are both high:
  - Not last: clear mask_q[cur_idx] and advance cur_idx to the next set bit. Disabled bytes are skipped with zero bubble cycles.
  - Last: if a new word is accepted in the same cycle, load it (see simultaneous accept below). Otherwise go to IDLE.
- in_ready = (state == IDLE) || (out_valid && out_ready && out_last). This is combinational from out_ready; no other combinational paths exist.
- When out_valid is high and out_ready is low, out_data, out_idx and out_last hold stable.
- in_data and in_keep are ignored whenever in_ready is low.

## Timing
- Reset values: state = IDLE, out_valid = 0, out_last = 0, out_data = 0, out_idx = 0, mask_q = 0. in_ready is 1 in the cycle after reset deasserts.
- While rst is high, in_ready = 0.
- Latency: a word accepted at edge N has its first byte valid from N+1. Outputs are registered.
- Throughput: one byte per cycle under continuous out_ready.
- Back-to-back words: a word with K kept bytes occupies exactly K output cycles with no gap between words.
- Simultaneous accept and last-byte handshake: the new word loads. If its keep is nonzero, out_valid stays 1 and the first byte of the new word appears the next cycle. If its keep is 0, the word drops and out_valid falls to 0.
- Reset mid-word: the held word is discarded. Its pending bytes are never emitted and outputs return to their reset values at the next edge.
- out_last is asserted only together with out_valid.

## Structure
- Shared package word_ser_pkg:
  - state enum: IDLE, SEND.
  - BYTE_W = 8.
  - a function that returns the next set index of a mask, given a start index and a direction.
- One sub-module, byte_pick: a parameterized priority encoder. Inputs are the mask, the current index and MSB_FIRST. Outputs are next_idx and none_left, which drives out_last and the initial index. It is instantiated once for the current word and once for the incoming word.
- Top level: handshake, state register, word_q/mask_q/cur_idx registers, and the byte mux.

## Test plan
- in_data = 32'hdeadbeaf, keep = 4'hf, MSB_FIRST = 0, out_ready held 1 -> bytes af, be, ad, de on four consecutive cycles; out_idx 0, 1, 2, 3; out_last only on de.
- Same word with keep = 4'b1010 -> bytes be then de, out_idx 1 then 3, out_last on de; no idle cycles between them.
- MSB_FIRST = 1, keep = 4'hf -> bytes de, ad, be, af; out_idx 3, 2, 1, 0.
- out_ready toggled 1, 0, 0, 1 during 32'h11223344 -> each byte holds stable while stalled; output sequence 44, 33, 22, 11 with none dropped or duplicated.
- Words 32'hdeadbeaf (keep 4'hf), 32'h0 (keep 0) and 32'h11223344 (keep 4'b0001) presented back-to-back with in_valid held high -> the keep-0 word is accepted with no output; the stream is af, be, ad, de, 44.
- Assert rst for one cycle after byte be of 32'hdeadbeaf -> next cycle out_valid = 0 and in_ready = 0; in_ready = 1 the cycle after reset deasserts; ad and de are never emitted.
